// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout and bubble encoding.
package cpu_pipe_pkg;

    localparam int CTRL_W = 12;

    // Control bundle bit positions
    localparam int REG_WRITE  = 0;
    localparam int MEM_TO_REG = 1;
    localparam int MEM_READ   = 2;
    localparam int MEM_WRITE  = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;
    localparam int BRANCH     = 6;
    localparam int USES_RT    = 7;
    localparam int ALU_OP_LO  = 8;
    localparam int ALU_OP_HI  = 11;

    // A bubble carries no side effects: every control bit is clear.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the instruction in EX is a load whose destination
// is a source of the instruction in ID. Purely combinational.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic       id_uses_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    // $zero is never a real dependency, and rt only matters when ID reads it
    always_comb begin
        rs_hit = (ex_rt == id_rs);
        rt_hit = id_uses_rt & (ex_rt == id_rt);
        lu     = ex_valid & ex_mem_read & id_valid & (ex_rt != 5'd0) & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, hold, flush and a saturating
// count of load-use bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = cpu_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import cpu_pipe_pkg::*;

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic [4:0]        shamt_q,   shamt_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              lu;

    load_use_detect u_lu (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q[MEM_READ]),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_uses_rt  (id_ctrl[USES_RT]),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .lu          (lu)
    );

    // Stall upstream on hold or an unflushed load-use; quiet during reset
    always_comb begin
        id_stall = ~reset & (hold | (lu & ~flush));
    end

    // Next state: hold freezes, flush/load-use insert a zeroed bubble,
    // otherwise capture ID. Reset is applied in the flop block.
    always_comb begin
        valid_d   = id_valid;
        ctrl_d    = id_ctrl;
        pc4_d     = id_pc4;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm_ext;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        shamt_d   = id_shamt;
        cnt_d     = cnt_q;
        if (hold) begin
            valid_d   = valid_q;
            ctrl_d    = ctrl_q;
            pc4_d     = pc4_q;
            rs_data_d = rs_data_q;
            rt_data_d = rt_data_q;
            imm_d     = imm_q;
            rs_d      = rs_q;
            rt_d      = rt_q;
            rd_d      = rd_q;
            shamt_d   = shamt_q;
        end else if (flush || lu) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_W'(BUBBLE_CTRL);
            pc4_d     = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            shamt_d   = '0;
            // only load-use bubbles are counted, and the count saturates
            if (!flush && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            shamt_q   <= shamt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm_ext = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_shamt   = shamt_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: driver queues hand-computed
// expectations, an independent monitor pops and compares each cycle.
module tb_id_ex_stage_reg;

    typedef struct {
        bit          valid;
        logic [11:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, sh;
    } ins_t;

    typedef struct {
        string       nm;
        bit          stall;
        ins_t        ex;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [11:0] id_ctrl;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        id_stall, ex_valid;
    logic [11:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [31:0] bubble_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .CTRL_W(12), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .bubble_cnt(bubble_cnt)
    );

    function automatic logic [160:0] pack(input ins_t i);
        return {i.valid, i.ctrl, i.pc4, i.rsd, i.rtd, i.imm, i.rs, i.rt, i.rd, i.sh};
    endfunction

    function automatic ins_t mk(input bit v, input logic [11:0] c, input logic [31:0] pc4,
                                input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sh);
        ins_t i;
        i.valid = v; i.ctrl = c; i.pc4 = pc4; i.rsd = rsd; i.rtd = rtd; i.imm = imm;
        i.rs = rs; i.rt = rt; i.rd = rd; i.sh = sh;
        return i;
    endfunction

    // Drive one cycle of ID inputs and queue the expected response
    task automatic step(input string nm, input bit r, input bit h, input bit f, input ins_t id,
                        input bit e_stall, input ins_t e_ex, input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset = r; hold = h; flush = f;
        id_valid = id.valid; id_ctrl = id.ctrl; id_pc4 = id.pc4;
        id_rs_data = id.rsd; id_rt_data = id.rtd; id_imm_ext = id.imm;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd; id_shamt = id.sh;
        e.nm = nm; e.stall = e_stall; e.ex = e_ex; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    // Monitor: stall sampled before the edge, EX state after it
    initial begin
        exp_t e;
        logic [160:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                busy = 1;
                checks++;
                if (id_stall !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall: got %b want %b", e.nm, id_stall, e.stall);
                end
                @(posedge clk);
                #1;
                act = {ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
                       ex_rs, ex_rt, ex_rd, ex_shamt};
                checks++;
                if (act !== pack(e.ex)) begin
                    errors++;
                    $display("FAIL %s ex: got %h want %h", e.nm, act, pack(e.ex));
                end
                checks++;
                if (bubble_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s cnt: got %0d want %0d", e.nm, bubble_cnt, e.cnt);
                end
                busy = 0;
            end
        end
    end

    initial begin
        ins_t bub, a, l, d, l2, ai, l3, s, z, z0, l4, inv, l5, fa, l6, ha;
        int   n;
        bub = mk(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        // ctrl: REG_WRITE=1 MEM_TO_REG=2 MEM_READ=4 ALU_SRC=10 REG_DST=20 USES_RT=80
        a   = mk(1, 12'h011, 32'h00400004, 32'h11111111, 32'h22222222, 32'hFFFF8000, 3, 4, 0, 0);
        l   = mk(1, 12'h017, 32'h00400008, 32'h00001000, 32'h0, 32'h4, 3, 5, 0, 0);
        d   = mk(1, 12'h2A1, 32'h0040000C, 32'hA, 32'hB, 32'h0, 5, 6, 7, 0);
        l2  = mk(1, 12'h017, 32'h00400010, 32'h0, 32'h0, 32'h8, 2, 5, 0, 0);
        ai  = mk(1, 12'h011, 32'h00400014, 32'h3, 32'h4, 32'h00000005, 1, 5, 0, 0);
        l3  = mk(1, 12'h017, 32'h00400018, 32'h0, 32'h0, 32'hC, 2, 9, 0, 0);
        s   = mk(1, 12'h6A1, 32'h0040001C, 32'h5, 32'h6, 32'h0, 2, 9, 10, 3);
        z   = mk(1, 12'h017, 32'h00400020, 32'h0, 32'h0, 32'h10, 4, 0, 0, 0);
        z0  = mk(1, 12'h0A1, 32'h00400024, 32'h0, 32'h0, 32'h0, 0, 0, 12, 0);
        l4  = mk(1, 12'h017, 32'h00400028, 32'h0, 32'h0, 32'h14, 4, 8, 0, 0);
        inv = mk(0, 12'h0A1, 32'h0040002C, 32'h7, 32'h8, 32'h0, 8, 1, 13, 0);
        l5  = mk(1, 12'h017, 32'h00400030, 32'h0, 32'h0, 32'h18, 4, 10, 0, 0);
        fa  = mk(1, 12'h0A1, 32'h00400034, 32'h9, 32'h9, 32'h0, 10, 2, 14, 0);
        l6  = mk(1, 12'h017, 32'h00400038, 32'h0, 32'h0, 32'h1C, 4, 11, 0, 0);
        ha  = mk(1, 12'h0A1, 32'h0040003C, 32'hDEADBEEF, 32'h1, 32'h0, 11, 3, 15, 4);

        step("rst0",      1, 0, 0, l,   0, bub, 0);
        step("rst1",      1, 0, 0, bub, 0, bub, 0);
        step("capture",   0, 0, 0, a,   0, a,   0);
        step("lw",        0, 0, 0, l,   0, l,   0);
        step("lu_rs",     0, 0, 0, d,   1, bub, 1);
        step("lu_rs_rel", 0, 0, 0, d,   0, d,   1);
        step("lw2",       0, 0, 0, l2,  0, l2,  1);
        step("rt_unused", 0, 0, 0, ai,  0, ai,  1);
        step("lw3",       0, 0, 0, l3,  0, l3,  1);
        step("lu_rt",     0, 0, 0, s,   1, bub, 2);
        step("lu_rt_rel", 0, 0, 0, s,   0, s,   2);
        step("lw_r0",     0, 0, 0, z,   0, z,   2);
        step("reg_zero",  0, 0, 0, z0,  0, z0,  2);
        step("lw4",       0, 0, 0, l4,  0, l4,  2);
        step("id_inval",  0, 0, 0, inv, 0, inv, 2);
        step("lw5",       0, 0, 0, l5,  0, l5,  2);
        step("flush_lu",  0, 0, 1, fa,  0, bub, 2);
        step("lw6",       0, 0, 0, l6,  0, l6,  2);
        step("hold0",     0, 1, 0, ha,  1, l6,  2);
        step("hold1",     0, 1, 0, ha,  1, l6,  2);
        step("hold2",     0, 1, 0, ha,  1, l6,  2);
        step("rst_lu",    1, 0, 0, ha,  0, bub, 0);
        step("post_rst",  0, 0, 0, ha,  0, ha,  0);

        n = 0;
        while ((q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain: monitor left %0d entries", q.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
